// File: rtl/cordic_multiplier_approx_2u6.sv
// rtl/cordic_multiplier_approx_2u6.sv - sequential linear-mode CORDIC multiplier, y ~= x*z.
// Define CORDIC_APPROX_ADD_EN to use the lower-part-OR approximate accumulator adder.
module cordic_multiplier_approx_2u6 #(
  parameter int WIDTH       = 8,
  parameter int APPROX_LSBS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     x,
  input  logic [WIDTH-1:0]     z,
  output logic [2*WIDTH-1:0]   y,
  output logic                 done
);

  localparam int AW = 2 * WIDTH;
  localparam int RW = WIDTH + 2;
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic [AW-1:0] r_x;
  logic [RW-1:0] r_r;
  logic [AW-1:0] r_acc;
  logic [IW-1:0] r_i;
  logic [AW-1:0] r_y;
  logic          r_done;

  logic [AW-1:0] w_shifted;
  logic [AW-1:0] w_operand;
  logic [RW-1:0] w_pow;
  logic [RW-1:0] w_r_next;
  logic [AW-1:0] w_sum;
  logic          w_pos;
  logic          w_neg;

  // Direction d comes from the sign of the residual; d=0 leaves both paths untouched.
  always_comb begin
    w_neg     = r_r[RW-1];
    w_pos     = !r_r[RW-1] && (|r_r);
    w_shifted = r_x << r_i;
    w_pow     = RW'(1) << r_i;
    w_operand = '0;
    w_r_next  = r_r;
    if (w_neg) begin
      w_operand = -w_shifted;
      w_r_next  = r_r + w_pow;
    end else if (w_pos) begin
      w_operand = w_shifted;
      w_r_next  = r_r - w_pow;
    end
  end

`ifdef CORDIC_APPROX_ADD_EN
  logic [APPROX_LSBS-1:0]    w_lo;
  logic                      w_cin;
  logic [AW-APPROX_LSBS-1:0] w_hi;

  // Low segment is a plain OR; only the top low bit pair generates a carry upward.
  always_comb begin
    w_lo  = r_acc[APPROX_LSBS-1:0] | w_operand[APPROX_LSBS-1:0];
    w_cin = r_acc[APPROX_LSBS-1] & w_operand[APPROX_LSBS-1];
    w_hi  = r_acc[AW-1:APPROX_LSBS] + w_operand[AW-1:APPROX_LSBS]
          + {{(AW-APPROX_LSBS-1){1'b0}}, w_cin};
    w_sum = {w_hi, w_lo};
  end
`else
  always_comb begin
    w_sum = r_acc + w_operand;
  end
`endif

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: if (start) w_state_next = S_CALC;
      S_CALC: if (r_i == '0) w_state_next = S_DONE;
      S_DONE: if (r_done && !start) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_x     <= '0;
      r_r     <= '0;
      r_acc   <= '0;
      r_i     <= '0;
      r_y     <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_x   <= {{WIDTH{x[WIDTH-1]}}, x};
            r_r   <= {{2{z[WIDTH-1]}}, z};
            r_acc <= '0;
            r_i   <= IW'(WIDTH - 1);
          end
        end
        S_CALC: begin
          r_acc <= w_sum;
          r_r   <= w_r_next;
          if (r_i != '0) r_i <= r_i - 1'b1;
        end
        S_DONE: begin
          // First DONE cycle registers the result; done then holds until start drops.
          if (!r_done) begin
            r_y    <= r_acc;
            r_done <= 1'b1;
          end else if (!start) begin
            r_done <= 1'b0;
          end
        end
        default: r_done <= 1'b0;
      endcase
    end
  end

  assign y    = r_y;
  assign done = r_done;

endmodule

// File: tb/tb_cordic_multiplier_approx_2u6.sv
// tb/tb_cordic_multiplier_approx_2u6.sv - randomized self-checking bench for cordic_multiplier_approx_2u6.
// Follows CORDIC_APPROX_ADD_EN the same way as the design.
module tb_cordic_multiplier_approx_2u6;

  localparam int L = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  x;
  logic [7:0]  z;
  logic [15:0] y;
  logic        done;

  int total = 0;
  int bad   = 0;

  cordic_multiplier_approx_2u6 dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .x     (x),
    .z     (z),
    .y     (y),
    .done  (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int approx_add(input int a, input int b);
    int lo, c, hi;
    lo = (a | b) & ((1 << L) - 1);
    c  = ((a >> (L - 1)) & (b >> (L - 1))) & 1;
    hi = ((a >> L) & ((1 << (16 - L)) - 1)) + ((b >> L) & ((1 << (16 - L)) - 1)) + c;
    return ((hi & ((1 << (16 - L)) - 1)) << L) | lo;
  endfunction

  // Reference: greedy signed-digit decomposition of z, summing +/- x*2^i terms.
  function automatic int model(input int a, input int b);
    int r, acc, term;
    r   = b;
    acc = 0;
    for (int i = 7; i >= 0; i--) begin
      term = 0;
      if (r > 0) begin
        term = a * (1 << i);
        r    = r - (1 << i);
      end else if (r < 0) begin
        term = -a * (1 << i);
        r    = r + (1 << i);
      end
`ifdef CORDIC_APPROX_ADD_EN
      acc = approx_add(acc, term & 16'hffff);
`else
      acc = (acc + term) & 16'hffff;
`endif
    end
    if (acc >= 32768) acc = acc - 65536;
    return acc;
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // Issues one start pulse (or holds start), returns the result and clocks-to-done.
  task automatic do_op(input int a, input int b, input bit hold, output int res, output int lat);
    int av, bv;
    av = a;
    bv = b;
    @(negedge clk);
    x     = av[7:0];
    z     = bv[7:0];
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if (!hold) start = 1'b0;
    lat = 0;
    while (!done && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    res = $signed(y);
  endtask

  int res, lat, p, held_y;
  int bnd;
  real rel, rel_max, rel_sum;
  int  rel_n;

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    x     = '0;
    z     = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      chk("reset_y", $signed(y), 0);
      chk("reset_done", int'(done), 0);
    end

    do_op(5, 6, 1'b0, res, lat);
    chk("lat_5x6", lat, 9);
`ifndef CORDIC_APPROX_ADD_EN
    chk("y_5x6", res, 30);
`endif
    chk("model_5x6", res, model(5, 6));
    @(posedge clk);
    @(negedge clk);
    chk("done_fall_pulse", int'(done), 0);

`ifndef CORDIC_APPROX_ADD_EN
    do_op(127, 127, 1'b0, res, lat);   chk("y_127x127", res, 16129);
    do_op(-128, -128, 1'b0, res, lat); chk("y_m128xm128", res, 16384);
    do_op(127, -128, 1'b0, res, lat);  chk("y_127xm128", res, -16256);
    do_op(-7, 1, 1'b0, res, lat);      chk("y_m7x1", res, -7);
`endif
    do_op(99, 0, 1'b0, res, lat);      chk("y_99x0", res, 0);
    do_op(0, -77, 1'b0, res, lat);     chk("y_0xm77", res, 0);
    chk("lat_0xm77", lat, 9);

    do_op(-45, 23, 1'b1, res, lat);
    chk("hold_lat", lat, 9);
    chk("hold_y", res, model(-45, 23));
    held_y = res;
    x = 8'd3;
    z = 8'd3;
    repeat (6) begin
      @(posedge clk);
      @(negedge clk);
      chk("hold_done", int'(done), 1);
      chk("hold_y_stable", $signed(y), held_y);
    end
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("hold_release_done", int'(done), 0);
    do_op(3, 3, 1'b0, res, lat);
    chk("restart_y", res, model(3, 3));

    @(negedge clk);
    x     = 8'd50;
    z     = 8'd40;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    begin
      int seen;
      seen = 0;
      repeat (15) begin
        @(posedge clk);
        @(negedge clk);
        if (done) seen = 1;
      end
      chk("abort_no_done", seen, 0);
    end
    chk("abort_y", $signed(y), 0);
    do_op(13, -11, 1'b0, res, lat);
    chk("after_abort_y", res, model(13, -11));
    chk("after_abort_lat", lat, 9);

    rel_max = 0.0;
    rel_sum = 0.0;
    rel_n   = 0;
    bnd     = (1 << L) * 9;
    for (int n = 0; n < 400; n++) begin
      int a, b;
      a = int'($urandom_range(255)) - 128;
      b = int'($urandom_range(255)) - 128;
      if (n % 50 == 0) a = 0;
      if (n % 50 == 1) b = 0;
      do_op(a, b, 1'b0, res, lat);
      p = a * b;
      chk($sformatf("rand_model_%0dx%0d", a, b), res, model(a, b));
      if (lat != 9) chk("rand_lat", lat, 9);
      if (a == 0 || b == 0) chk("rand_zero", res, 0);
`ifdef CORDIC_APPROX_ADD_EN
      if (iabs(res - p) > bnd) chk($sformatf("approx_bound_%0dx%0d", a, b), res, p);
`else
      if (iabs(res - p) > iabs(a)) chk($sformatf("exact_bound_%0dx%0d", a, b), res, p);
`endif
      if (p != 0) begin
        rel = real'(iabs(res - p)) / real'(iabs(p));
        rel_sum += rel;
        rel_n++;
        if (rel > rel_max) rel_max = rel;
      end
    end
    if (rel_n > 0)
      $display("relative error: max=%f mean=%f over %0d products", rel_max, rel_sum / rel_n, rel_n);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
